// File: rtl/conv_pkg.sv
// Shared constants, default tag layout and FSM encoding for the conv-layer window scheduler.
package conv_pkg;

    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;
    localparam int DEF_OUT_CH     = 8;
    localparam int DEF_MAC_LAT    = 3;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DATA_W     = 18;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [idx_w(DEF_IMG_H-2)-1:0] row;
        logic [idx_w(DEF_IMG_W-2)-1:0] col;
        logic [idx_w(DEF_OUT_CH)-1:0]  ch;
    } tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fsm_t;

endpackage

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO; an empty FIFO forwards the incoming word straight to the head.
module mac_result_fifo import conv_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign empty      = (count_reg == '0);
    assign head_valid = !empty || push;
    assign head_data  = !empty ? mem[rd_ptr_reg] : (push ? push_data : '0);
    assign count      = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Push+pop on an empty FIFO moves both pointers, so the bypassed word never lingers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_reg == CW'(DEPTH))));

endmodule

// File: rtl/conv_window_sched.sv
// Walks every 3x3 window per output channel, tags each MAC issue and re-aligns the tag with the
// late MAC result before handing both to a credit-protected result FIFO.
module conv_window_sched import conv_pkg::*; #(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int OUT_CH     = DEF_OUT_CH,
    parameter int MAC_LAT    = DEF_MAC_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    localparam int RW = idx_w(IMG_H-2),
    localparam int CW = idx_w(IMG_W-2),
    localparam int HW = idx_w(OUT_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              win_valid,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic [HW-1:0]     win_ch,
    input  logic [DATA_W-1:0] mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [RW-1:0]     res_row,
    output logic [CW-1:0]     res_col,
    output logic [HW-1:0]     res_ch
);

    localparam int TW  = RW + CW + HW;
    localparam int NW  = idx_w(MAC_LAT+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-3);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-3);
    localparam logic [HW-1:0] CH_LAST  = HW'(OUT_CH-1);

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [HW-1:0] ch;
    } win_tag_t;

    fsm_t          state_reg, state_next;
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic [HW-1:0] ch_reg, ch_next;
    logic [NW-1:0] inflight_reg;
    logic [MAC_LAT-1:0]     pipe_vld_reg, pipe_vld_next;
    win_tag_t [MAC_LAT-1:0] pipe_tag_reg, pipe_tag_next;
    win_tag_t               cur_tag, head_tag;
    logic [DATA_W+TW-1:0]   head_word;
    logic [FCW-1:0]         fifo_count;
    logic                   issue, push, pop;

    // Credit: results already queued plus those still inside the MAC must fit in the FIFO.
    assign issue   = (state_reg == ST_RUN) &&
                     ((int'(fifo_count) + int'(inflight_reg)) < FIFO_DEPTH);
    assign push    = pipe_vld_reg[MAC_LAT-1];
    assign pop     = res_valid && res_ready;
    assign cur_tag = '{row: row_reg, col: col_reg, ch: ch_reg};

    assign pipe_vld_next[0] = issue;
    assign pipe_tag_next[0] = cur_tag;
    for (genvar gi = 1; gi < MAC_LAT; gi++) begin : g_tag_shift
        assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
        assign pipe_tag_next[gi] = pipe_tag_reg[gi-1];
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        ch_next    = ch_reg;
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        unique case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (issue) begin
                    if (col_reg != COL_LAST) begin
                        col_next = col_reg + CW'(1);
                    end else begin
                        col_next = '0;
                        if (row_reg != ROW_LAST) begin
                            row_next = row_reg + RW'(1);
                        end else begin
                            row_next = '0;
                            if (ch_reg != CH_LAST) begin
                                ch_next = ch_reg + HW'(1);
                            end else begin
                                ch_next    = '0;
                                state_next = ST_DRAIN;
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight_reg == '0) && (fifo_count == '0)) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The MAC has no stall, so the tag pipe shifts every cycle regardless of issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            ch_reg       <= '0;
            inflight_reg <= '0;
            pipe_vld_reg <= '0;
            pipe_tag_reg <= '0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            ch_reg       <= ch_next;
            inflight_reg <= inflight_reg + NW'(issue) - NW'(push);
            pipe_vld_reg <= pipe_vld_next;
            pipe_tag_reg <= pipe_tag_next;
        end
    end

    assign win_valid = issue;
    assign win_row   = row_reg;
    assign win_col   = col_reg;
    assign win_ch    = ch_reg;

    mac_result_fifo #(
        .WIDTH (DATA_W + TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ({mac_result, pipe_tag_reg[MAC_LAT-1]}),
        .pop        (pop),
        .head_valid (res_valid),
        .head_data  (head_word),
        .count      (fifo_count)
    );

    assign head_tag = head_word[TW-1:0];
    assign res_data = head_word[DATA_W+TW-1:TW];
    assign res_row  = head_tag.row;
    assign res_col  = head_tag.col;
    assign res_ch   = head_tag.ch;

endmodule
